led_bank_scheduler: RTL

- Owns the 8-LED bar and shares it between two pattern requesters.
- Grants the bar round-robin and plays the granted pattern (scan, blink, fill or blank) at a prescaled step rate for a programmed number of repetitions.
- Signals completion and returns the bar to idle.
- Sits between the board top level (hwclk, led1..led8) and the pattern-requesting logic, replacing the free-running scanner.

---
 rtl/led_bank_scheduler.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/led_bank_scheduler.sv
// -----------------------------------------------------------------------------
// led_bank_scheduler
//   Owns the 8-LED bar and lends it to one of two requesters at a time.
//   Each run plays the winner's pattern (off, scan, blink or fill), one step
//   per prescaler period, for reps+1 passes. The bar then returns to idle.
//
// Ports:
//   hwclk          system clock
//   rst_n          asynchronous active-low reset
//   req[1:0]       per-requester request
//   mode0/mode1    pattern select: 0 OFF, 1 SCAN, 2 BLINK, 3 FILL
//   reps0/reps1    extra repetitions (total plays = reps+1)
//   abort          ends the current run early, without a done pulse
//   grant[1:0]     one-hot grant, held for the whole run
//   busy           high while a run is in progress
//   done           one-cycle pulse after a run completes normally
//   leds[7:0]      LED drive, bit0 = led1
// -----------------------------------------------------------------------------
module led_bank_scheduler #(
   parameter int DIV_BITS = 20
) (
   input  logic       hwclk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [1:0] mode0,
   input  logic [3:0] reps0,
   input  logic [1:0] mode1,
   input  logic [3:0] reps1,
   input  logic       abort,
   output logic [1:0] grant,
   output logic       busy,
   output logic       done,
   output logic [7:0] leds
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DIV_BITS-1:0] r_presc;
   logic [DIV_BITS-1:0] w_presc_nxt;
   logic [3:0]          r_step;
   logic [3:0]          w_step_nxt;
   logic [3:0]          r_rep;
   logic [3:0]          w_rep_nxt;
   logic [1:0]          r_mode_q;
   logic [1:0]          w_mode_nxt;
   logic [3:0]          r_reps_q;
   logic [3:0]          w_reps_nxt;
   logic                r_last;      // requester that held the bar most recently
   logic                w_last_nxt;
   logic [1:0]          r_grant;
   logic [1:0]          w_grant_nxt;
   logic                r_busy;
   logic                w_busy_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic [7:0]          r_leds;
   logic [7:0]          w_leds_nxt;
   logic                w_win;
   logic                w_finish;
   logic                w_tick;
   logic [3:0]          w_len;

   // Number of steps in one pass of a pattern.
   function automatic logic [3:0] pat_len(input logic [1:0] mode);
      case (mode)
         2'd0:    pat_len = 4'd1;
         2'd1:    pat_len = 4'd12;
         2'd2:    pat_len = 4'd2;
         2'd3:    pat_len = 4'd9;
         default: pat_len = 4'd1;
      endcase
   endfunction

   // LED value of a pattern at a given step.
   function automatic logic [7:0] pat_val(input logic [1:0] mode, input logic [3:0] step);
      logic [8:0] fill;
      fill    = (9'd1 << step) - 9'd1;
      pat_val = 8'h00;
      case (mode)
         2'd1: begin
            // Two-lit bar walks up to the top, then back down without
            // repeating either end position.
            if (step <= 4'd6) begin
               pat_val = 8'h03 << step;
            end else begin
               pat_val = 8'hC0 >> (step - 4'd6);
            end
         end
         2'd2:    pat_val = step[0] ? 8'h00 : 8'hFF;
         2'd3:    pat_val = fill[7:0];
         default: pat_val = 8'h00;
      endcase
   endfunction

   assign w_tick = &r_presc;
   assign w_len  = pat_len(r_mode_q);

   // Next-state and next-output logic for the idle/run controller.
   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_step_nxt  = r_step;
      w_rep_nxt   = r_rep;
      w_mode_nxt  = r_mode_q;
      w_reps_nxt  = r_reps_q;
      w_last_nxt  = r_last;
      w_grant_nxt = r_grant;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_leds_nxt  = r_leds;
      w_finish    = 1'b0;
      // With both requesting, the one that did not hold the bar last wins.
      w_win       = (req == 2'b11) ? ~r_last : req[1];

      case (r_state)
         ST_IDLE: begin
            w_grant_nxt = 2'b00;
            w_busy_nxt  = 1'b0;
            w_leds_nxt  = 8'h00;
            if (req != 2'b00) begin
               w_mode_nxt  = w_win ? mode1 : mode0;
               w_reps_nxt  = w_win ? reps1 : reps0;
               w_state_nxt = ST_RUN;
               w_presc_nxt = '0;
               w_step_nxt  = 4'd0;
               w_rep_nxt   = 4'd0;
               w_grant_nxt = w_win ? 2'b10 : 2'b01;
               w_busy_nxt  = 1'b1;
               w_leds_nxt  = pat_val(w_mode_nxt, 4'd0);
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            w_presc_nxt = r_presc + DIV_BITS'(1);
            if (abort) begin
               w_finish = 1'b1;
            end else if (w_tick) begin
               if (r_step < (w_len - 4'd1)) begin
                  w_step_nxt = r_step + 4'd1;
                  w_leds_nxt = pat_val(r_mode_q, r_step + 4'd1);
               end else if (r_rep < r_reps_q) begin
                  w_step_nxt = 4'd0;
                  w_rep_nxt  = r_rep + 4'd1;
                  w_leds_nxt = pat_val(r_mode_q, 4'd0);
               end else begin
                  w_finish   = 1'b1;
                  w_done_nxt = 1'b1;
               end
            end else begin
               w_finish = 1'b0;
            end
            if (w_finish) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = 2'b00;
               w_busy_nxt  = 1'b0;
               w_leds_nxt  = 8'h00;
               w_last_nxt  = r_grant[1];
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 2'b00;
            w_busy_nxt  = 1'b0;
            w_leds_nxt  = 8'h00;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_presc  <= '0;
         r_step   <= 4'd0;
         r_rep    <= 4'd0;
         r_mode_q <= 2'd0;
         r_reps_q <= 4'd0;
         r_last   <= 1'b1;
         r_grant  <= 2'b00;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_leds   <= 8'h00;
      end else begin
         r_state  <= w_state_nxt;
         r_presc  <= w_presc_nxt;
         r_step   <= w_step_nxt;
         r_rep    <= w_rep_nxt;
         r_mode_q <= w_mode_nxt;
         r_reps_q <= w_reps_nxt;
         r_last   <= w_last_nxt;
         r_grant  <= w_grant_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_leds   <= w_leds_nxt;
      end
   end

   assign grant = r_grant;
   assign busy  = r_busy;
   assign done  = r_done;
   assign leds  = r_leds;

endmodule
